// File: rtl/remote_tx_arbiter.sv
// Remote TX arbiter: two per-requester FIFOs feeding a header/addr/data network packetiser.
// Define REMOTE_TX_RR_EN for round-robin arbitration; default build uses fixed priority (B wins).
module remote_tx_arbiter #(
  parameter int ADDRX = 0,
  parameter int ADDRY = 0,
  parameter int DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        a_valid,
  input  logic [7:0]  a_des,
  input  logic [7:0]  a_type,
  input  logic [7:0]  a_len,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [7:0]  b_des,
  input  logic [7:0]  b_type,
  input  logic [7:0]  b_len,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_data,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        a_ovf,
  output logic        b_ovf,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 88;
  localparam logic [7:0] SRC = {4'd0, ADDRX[1:0], ADDRY[1:0]};

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_ADDR, S_DATA} state_t;

  // Entry layout: {des[87:80], type[79:72], len[71:64], addr[63:32], data[31:0]}
  logic [EW-1:0] r_a_mem [DEPTH];
  logic [EW-1:0] r_b_mem [DEPTH];
  logic [AW:0]   r_a_wr, r_a_rd, r_b_wr, r_b_rd;
  logic          r_a_ovf, r_b_ovf;

  state_t        r_state;
  logic [7:0]    r_type;
  logic [31:0]   r_addr, r_data, r_tx_data;
  logic          r_tx_valid, r_tx_last;
`ifdef REMOTE_TX_RR_EN
  logic          r_rr_b;
`endif

  logic          w_a_empty, w_b_empty, w_a_full, w_b_full;
  logic          w_a_push, w_b_push, w_a_pop, w_b_pop;
  logic          w_grant_any, w_grant_b;
  logic [EW-1:0] w_head;

  assign w_a_empty = (r_a_wr == r_a_rd);
  assign w_b_empty = (r_b_wr == r_b_rd);
  assign w_a_full  = (r_a_wr[AW] != r_a_rd[AW]) && (r_a_wr[AW-1:0] == r_a_rd[AW-1:0]);
  assign w_b_full  = (r_b_wr[AW] != r_b_rd[AW]) && (r_b_wr[AW-1:0] == r_b_rd[AW-1:0]);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
  assign w_a_push  = a_valid && !w_a_full && !HRESET;
  assign w_b_push  = b_valid && !w_b_full && !HRESET;

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_b   = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant_any = !w_a_empty || !w_b_empty;
`ifdef REMOTE_TX_RR_EN
      if (!w_a_empty && !w_b_empty) w_grant_b = r_rr_b;
      else                          w_grant_b = !w_b_empty;
`else
      w_grant_b = !w_b_empty;
`endif
    end
  end

  assign w_a_pop = w_grant_any && !w_grant_b && !HRESET;
  assign w_b_pop = w_grant_any && w_grant_b && !HRESET;
  assign w_head  = w_grant_b ? r_b_mem[r_b_rd[AW-1:0]] : r_a_mem[r_a_rd[AW-1:0]];

  always_ff @(posedge HCLK) begin
    if (w_a_push) r_a_mem[r_a_wr[AW-1:0]] <= {a_des, a_type, a_len, a_addr, a_data};
    if (w_b_push) r_b_mem[r_b_wr[AW-1:0]] <= {b_des, b_type, b_len, b_addr, b_data};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_a_wr  <= '0;
      r_a_rd  <= '0;
      r_b_wr  <= '0;
      r_b_rd  <= '0;
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else begin
      if (w_a_push) r_a_wr <= r_a_wr + 1'b1;
      if (w_a_pop)  r_a_rd <= r_a_rd + 1'b1;
      if (w_b_push) r_b_wr <= r_b_wr + 1'b1;
      if (w_b_pop)  r_b_rd <= r_b_rd + 1'b1;
      if (a_valid && w_a_full) r_a_ovf <= 1'b1;
      if (b_valid && w_b_full) r_b_ovf <= 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_type     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
`ifdef REMOTE_TX_RR_EN
      r_rr_b     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_any) begin
          r_state    <= S_HDR;
          r_type     <= w_head[79:72];
          r_addr     <= w_head[63:32];
          r_data     <= w_head[31:0];
          r_tx_data  <= {w_head[87:80], SRC, w_head[79:64]};
          r_tx_valid <= 1'b1;
          r_tx_last  <= 1'b0;
`ifdef REMOTE_TX_RR_EN
          r_rr_b     <= !w_grant_b;
`endif
        end
        S_HDR: if (tx_ready) begin
          r_state   <= S_ADDR;
          r_tx_data <= r_addr;
          r_tx_last <= (r_type != 8'h01);
        end
        S_ADDR: if (tx_ready) begin
          if (r_type == 8'h01) begin
            r_state   <= S_DATA;
            r_tx_data <= r_data;
            r_tx_last <= 1'b1;
          end else begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
          end
        end
        S_DATA: if (tx_ready) begin
          r_state    <= S_IDLE;
          r_tx_data  <= '0;
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign a_ovf    = r_a_ovf;
  assign b_ovf    = r_b_ovf;
  assign busy     = !w_a_empty || !w_b_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_remote_tx_arbiter.sv
// Bench for remote_tx_arbiter: packet-level queue model checked every cycle, plus literal pins.
// Follows REMOTE_TX_RR_EN the same way the DUT does.
module tb_remote_tx_arbiter;
  localparam int DEPTH = 4;
  localparam logic [7:0] SRC = 8'h00;

  logic HCLK = 1'b0, HRESET = 1'b1;
  logic a_valid = 0, b_valid = 0, tx_ready = 0;
  logic [7:0] a_des = 0, a_type = 0, a_len = 0, b_des = 0, b_type = 0, b_len = 0;
  logic [31:0] a_addr = 0, a_data = 0, b_addr = 0, b_data = 0;
  logic [31:0] tx_data;
  logic tx_valid, tx_last, a_ovf, b_ovf, busy;

  remote_tx_arbiter #(.ADDRX(0), .ADDRY(0), .DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .a_valid(a_valid), .a_des(a_des), .a_type(a_type), .a_len(a_len), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_des(b_des), .b_type(b_type), .b_len(b_len), .b_addr(b_addr), .b_data(b_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .a_ovf(a_ovf), .b_ovf(b_ovf), .busy(busy));

  always #5 HCLK = ~HCLK;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: requester queues, the word list of the packet in flight, sticky flags.
  typedef logic [87:0] ent_t;
  ent_t qa[$], qb[$];
  logic [32:0] words[$];
  logic [32:0] log_q[$];
  bit m_aovf = 0, m_bovf = 0, m_on = 0;
`ifdef REMOTE_TX_RR_EN
  bit m_rrb = 0;
`endif

  task automatic build(input ent_t e);
    words.push_back({1'b0, e[87:80], SRC, e[79:64]});
    if (e[79:72] == 8'h01) begin
      words.push_back({1'b0, e[63:32]});
      words.push_back({1'b1, e[31:0]});
    end else begin
      words.push_back({1'b1, e[63:32]});
    end
  endtask

  always @(posedge HCLK) begin
    bit fa, fb, pick_b;
    if (HRESET) begin
      qa.delete(); qb.delete(); words.delete();
      m_aovf = 0; m_bovf = 0; m_on = 1;
`ifdef REMOTE_TX_RR_EN
      m_rrb = 0;
`endif
    end else if (m_on) begin
      fa = (qa.size() == DEPTH);
      fb = (qb.size() == DEPTH);
      if (words.size() > 0) begin
        if (tx_ready) void'(words.pop_front());
      end else if (qa.size() > 0 || qb.size() > 0) begin
`ifdef REMOTE_TX_RR_EN
        pick_b = (qa.size() > 0 && qb.size() > 0) ? m_rrb : (qb.size() > 0);
        m_rrb = !pick_b;
`else
        pick_b = (qb.size() > 0);
`endif
        if (pick_b) build(qb.pop_front());
        else        build(qa.pop_front());
      end
      if (a_valid) begin
        if (fa) m_aovf = 1;
        else    qa.push_back({a_des, a_type, a_len, a_addr, a_data});
      end
      if (b_valid) begin
        if (fb) m_bovf = 1;
        else    qb.push_back({b_des, b_type, b_len, b_addr, b_data});
      end
    end
  end

  always @(negedge HCLK) begin
    if (m_on && !HRESET) begin
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, words.size() > 0});
      chk("busy", {31'd0, busy}, {31'd0, (qa.size() + qb.size() + words.size()) > 0});
      chk("a_ovf", {31'd0, a_ovf}, {31'd0, m_aovf});
      chk("b_ovf", {31'd0, b_ovf}, {31'd0, m_bovf});
      if (words.size() > 0) begin
        chk("tx_data", tx_data, words[0][31:0]);
        chk("tx_last", {31'd0, tx_last}, {31'd0, words[0][32]});
      end
      if (tx_valid && tx_ready) log_q.push_back({tx_last, tx_data});
    end
  end

  task automatic tick;
    @(posedge HCLK); #1;
  endtask

  task automatic step;
    tick;
    a_valid = 0; b_valid = 0;
  endtask

  task automatic set_a(input logic [7:0] d, t, l, input logic [31:0] ad, da);
    a_valid = 1; a_des = d; a_type = t; a_len = l; a_addr = ad; a_data = da;
  endtask

  task automatic set_b(input logic [7:0] d, t, l, input logic [31:0] ad, da);
    b_valid = 1; b_des = d; b_type = t; b_len = l; b_addr = ad; b_data = da;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || tx_valid) && n < 200) begin tick; n++; end
    chk({nm, "_done"}, {31'd0, n < 200}, 32'd1);
    tick;
  endtask

  task automatic chk_word(input string nm, input int i, input logic lst, input logic [31:0] d);
    if (i < log_q.size()) begin
      chk({nm, "_data"}, log_q[i][31:0], d);
      chk({nm, "_last"}, {31'd0, log_q[i][32]}, {31'd0, lst});
    end else begin
      chk({nm, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  logic [7:0]  exp_des [6];
  logic [31:0] exp_adr [6];

  initial begin
    tick; tick;
    HRESET = 0;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {30'd0, a_ovf, b_ovf}, 32'd0);
    tick;

    // single write, minimum latency
    log_q.delete(); tx_ready = 1;
    set_a(8'h05, 8'h01, 8'h04, 32'h0500_0010, 32'hDEADBEEF);
    step; step;
    chk("lat_valid", {31'd0, tx_valid}, 32'd1);
    chk("lat_hdr", tx_data, 32'h0500_0104);
    wait_idle("wr");
    chk("wr_count", log_q.size(), 32'd3);
    chk_word("wr0", 0, 1'b0, 32'h0500_0104);
    chk_word("wr1", 1, 1'b0, 32'h0500_0010);
    chk_word("wr2", 2, 1'b1, 32'hDEADBEEF);

    // single read on B
    log_q.delete();
    set_b(8'h0A, 8'h03, 8'h08, 32'h1000_0040, 32'h1234_5678);
    step;
    wait_idle("rd");
    chk("rd_count", log_q.size(), 32'd2);
    chk_word("rd0", 0, 1'b0, 32'h0A00_0308);
    chk_word("rd1", 1, 1'b1, 32'h1000_0040);

    // backpressure in ADDR for 5 cycles
    log_q.delete(); tx_ready = 0;
    set_a(8'h07, 8'h01, 8'h04, 32'h0700_0020, 32'hCAFE_F00D);
    step; repeat (2) tick;
    tx_ready = 1; tick;
    tx_ready = 0; repeat (3) tick;
    chk("bp_hold_data", tx_data, 32'h0700_0020);
    chk("bp_hold_valid", {31'd0, tx_valid}, 32'd1);
    repeat (2) tick;
    tx_ready = 1;
    wait_idle("bp");
    chk("bp_count", log_q.size(), 32'd3);
    chk_word("bp1", 1, 1'b0, 32'h0700_0020);
    chk_word("bp2", 2, 1'b1, 32'hCAFE_F00D);

    // arbitration with both queues loaded (reset puts the round-robin pointer on A)
    HRESET = 1; tick; HRESET = 0;
    log_q.delete(); tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_a(8'hA0 + 8'(i), 8'h03, 8'h00, 32'hA000_0000 + i, 32'h0);
      set_b(8'hB0 + 8'(i), 8'h03, 8'h00, 32'hB000_0000 + i, 32'h0);
      step;
    end
    tx_ready = 1;
    wait_idle("arb");
`ifdef REMOTE_TX_RR_EN
    exp_des = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`else
    exp_des = '{8'hB0, 8'hB1, 8'hB2, 8'hA0, 8'hA1, 8'hA2};
`endif
    chk("arb_count", log_q.size(), 32'd12);
    for (int j = 0; j < 6; j++)
      chk_word("arb_hdr", 2 * j, 1'b0, {exp_des[j], 8'h00, 8'h03, 8'h00});

    // overflow: one packet stalled in flight, then DEPTH+1 pulses, then pushes across a full-FIFO pop
    log_q.delete(); tx_ready = 0;
    set_a(8'h11, 8'h03, 8'h00, 32'h5000_0000, 32'h0);
    step; step;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      set_a(8'h11, 8'h03, 8'h00, 32'h5000_0000 + i, 32'h0);
      step;
    end
    chk("ovf_a", {31'd0, a_ovf}, 32'd1);
    chk("ovf_b", {31'd0, b_ovf}, 32'd0);
    tx_ready = 1;
    for (int k = 0; k < 4; k++) begin
      set_a(8'h11, 8'h03, 8'h00, 32'h5000_0100 + k, 32'h0);
      step;
    end
    wait_idle("ovf");
    exp_adr = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004, 32'h5000_0103};
    chk("ovf_count", log_q.size(), 32'd12);
    for (int j = 0; j < 6; j++) chk_word("ovf_adr", 2 * j + 1, 1'b1, exp_adr[j]);

    // reset mid-DATA, with a request pulse ignored during reset
    tx_ready = 1;
    set_a(8'h05, 8'h01, 8'h04, 32'h0500_0010, 32'h0BAD_F00D);
    step; step; step; step;
    chk("md_valid", {31'd0, tx_valid}, 32'd1);
    chk("md_data", tx_data, 32'h0BAD_F00D);
    HRESET = 1;
    set_b(8'h09, 8'h03, 8'h00, 32'h9000_0000, 32'h0);
    step;
    HRESET = 0;
    chk("mr_valid", {31'd0, tx_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ovf", {30'd0, a_ovf, b_ovf}, 32'd0);
    tick; tick;
    chk("mr_quiet", {31'd0, busy || tx_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/remote_tx_arbiter.md
REMOTE_TX_ARBITER -- requirements
Module: remote_tx_arbiter

Interface
REQ-001 Parameter ADDRX, default 0, local node X coordinate (2 bits used).
REQ-002 Parameter ADDRY, default 0, local node Y coordinate (2 bits used).
REQ-003 Parameter DEPTH, default 4, entries per requester queue; power of two, minimum 2.
REQ-004 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-005 HRESET  input  1  reset, synchronous, active-high.
REQ-006 a_valid  input  1  single-cycle request pulse from the local AHB remote-memory slave (requester A).
REQ-007 a_des, a_type, a_len  input  8 each  destination node, message type, byte length.
REQ-008 a_addr, a_data  input  32 each  remote memory address, write data.
REQ-009 b_valid, b_des, b_type, b_len, b_addr, b_data  input  1/8/8/8/32/32  same fields from the read-response source (requester B).
REQ-010 tx_data  output  32  network word.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_last  output  1  final word of the packet.
REQ-013 tx_ready  input  1  network accepts the word when tx_valid && tx_ready.
REQ-014 a_ovf, b_ovf  output  1 each  sticky overflow flags.
REQ-015 busy  output  1  high when any queue is non-empty or a packet is in flight.

Function
REQ-016 Each requester has its own FIFO of DEPTH entries storing {des, type, len, addr, data}; no backpressure toward requesters.
REQ-017 x_valid with FIFO not full: entry written that cycle; visible to the arbiter next cycle.
REQ-018 x_valid with FIFO full: entry dropped, x_ovf set and held until reset.
REQ-019 Same-cycle push and pop on a full FIFO: push is still dropped (full evaluated before pop).
REQ-020 Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
REQ-021 FSM states: IDLE, HDR, ADDR, DATA.
REQ-022 IDLE: if any FIFO non-empty, grant one per REQ-034/035, pop its head into the packet register, go to HDR next cycle; otherwise stay.
REQ-023 HDR: tx_data = {des, src, type, len}; src = {4'd0, ADDRX[1:0], ADDRY[1:0]}; advance to ADDR on handshake.
REQ-024 ADDR: tx_data = addr; on handshake go to DATA if type == 8'h1 (write), else to IDLE with tx_last = 1 (read: 2-word packet).
REQ-025 DATA: tx_data = data, tx_last = 1; on handshake go to IDLE.
REQ-026 tx_valid = 1 exactly in HDR, ADDR and DATA; tx_data/tx_last stable while tx_valid && !tx_ready.
REQ-027 Minimum latency: x_valid at cycle 0 -> header on tx with tx_valid at cycle 2 (FIFO empty, FSM IDLE).
REQ-028 Back-to-back packets: one IDLE cycle between the last word of one packet and the next header.
REQ-029 Both FIFOs empty in IDLE: tx_valid = 0, busy = 0.
REQ-030 Any type other than 8'h1 is sent as a 2-word packet.

Reset
REQ-031 HRESET high at a rising edge: FSM -> IDLE, both FIFOs emptied, a_ovf = b_ovf = 0, round-robin pointer -> A.
REQ-032 Reset outputs: tx_valid = 0, tx_last = 0, tx_data = 0, busy = 0.
REQ-033 Reset mid-packet abandons the packet; no further words of it are issued, and x_valid is ignored while HRESET is high.

Configuration
REQ-034 With REMOTE_TX_RR_EN defined: round-robin arbitration; after a grant the other requester has priority; both non-empty in IDLE alternate A, B, A, ...
REQ-035 Without REMOTE_TX_RR_EN: fixed priority, B (responses) always wins over A when both are non-empty.

Verification
REQ-036 Single write: a_valid, des=8'h05, type=8'h1, len=8'h4, addr=32'h0500_0010, data=32'hDEADBEEF, tx_ready=1 -> words 32'h0500_0104 (ADDRX=ADDRY=0), 32'h0500_0010, 32'hDEADBEEF, tx_last on the third word, header at cycle 2.
REQ-037 Single read: b_valid, type=8'h3 -> 2-word packet, tx_last on the address word, no data word.
REQ-038 Backpressure: tx_ready held 0 for 5 cycles in ADDR -> tx_data/tx_valid stable, no word lost or duplicated.
REQ-039 Overflow: DEPTH+1 consecutive a_valid pulses with tx_ready=0 -> first DEPTH entries sent in order, last dropped, a_ovf=1.
REQ-040 Arbitration: A and B both loaded with 3 entries each -> RR build order A,B,A,B,A,B; non-RR build all B then all A.
REQ-041 Reset mid-DATA: HRESET pulse while tx_valid=1 -> next cycle tx_valid=0, busy=0, flags 0.
